// File: rtl/blinky.sv
// Free-running 4-bit LED counter advanced by a DIV-cycle prescaler tick.
// The LED pins come straight from a register that already has the output polarity applied.
module blinky #(
  parameter int unsigned DIV             = 900000,
  parameter bit          LED_ACTIVE_HIGH = 1'b1
) (
  input  logic clki,
  input  logic rstn,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3
);

  localparam int unsigned     PW        = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]      LED_OFF   = LED_ACTIVE_HIGH ? 4'h0 : 4'hF;

  logic [PW-1:0] presc;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic [3:0]    led;
  logic          tick;

  always_comb begin
    tick     = (presc == PRESC_MAX);
    cnt_next = cnt + 4'd1;
  end

  // led is loaded from cnt_next on the tick edge so it changes together with cnt.
  always_ff @(posedge clki) begin
    if (!rstn) begin
      presc <= '0;
      cnt   <= '0;
      led   <= LED_OFF;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt_next;
      led   <= LED_ACTIVE_HIGH ? cnt_next : ~cnt_next;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign led0 = led[0];
  assign led1 = led[1];
  assign led2 = led[2];
  assign led3 = led[3];

endmodule

// File: tb/tb_blinky.sv
// Bench for blinky: DIV=4 in both polarities plus a DIV=1000 instance for drift checks.
module tb_blinky;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic h0, h1, h2, h3;
  logic l0, l1, l2, l3;
  logic b0, b1, b2, b3;
  logic [3:0] hi, lo, big;

  assign hi  = {h3, h2, h1, h0};
  assign lo  = {l3, l2, l1, l0};
  assign big = {b3, b2, b1, b0};

  always #5 clk = ~clk;

  blinky #(.DIV(4), .LED_ACTIVE_HIGH(1'b1)) u_hi (
    .clki(clk), .rstn(rstn), .led0(h0), .led1(h1), .led2(h2), .led3(h3)
  );
  blinky #(.DIV(4), .LED_ACTIVE_HIGH(1'b0)) u_lo (
    .clki(clk), .rstn(rstn), .led0(l0), .led1(l1), .led2(l2), .led3(l3)
  );
  blinky #(.DIV(1000), .LED_ACTIVE_HIGH(1'b1)) u_big (
    .clki(clk), .rstn(rstn), .led0(b0), .led1(b1), .led2(b2), .led3(b3)
  );

  typedef struct {
    logic        r;
    int unsigned n;
    logic [3:0]  hi;
    logic [3:0]  lo;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] big;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned run_len  = 0;  // edges with rstn high since the last reset edge

  function automatic logic [3:0] count_after(int unsigned div);
    return 4'((run_len / div) % 16);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, "_hi"},  hi,  e.hi);
      check({e.name, "_lo"},  lo,  e.lo);
      check({e.name, "_big"}, big, e.big);
    end
  endtask

  // Drive rstn, push expectations, clock n edges, then sample 1 ns after the last edge.
  task automatic apply(input logic r, input int unsigned n, input string name,
                       input logic [3:0] exp_hi, input logic [3:0] exp_lo);
    exp_t e;
    rstn = r;
    if (!r) run_len = 0;
    else    run_len += n;
    e.name = name;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    e.big  = r ? count_after(1000) : 4'h0;
    sb.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    compare_next();
  endtask

  task automatic apply_model(input logic r, input int unsigned n, input string name);
    int unsigned after;
    after = r ? run_len + n : 0;
    apply(r, n, name, 4'((after / 4) % 16), ~4'((after / 4) % 16));
  endtask

  initial begin
    vec_t v;

    v = '{r: 1'b0, n: 2, hi: 4'h0, lo: 4'hF}; vecs.push_back(v);
    v = '{r: 1'b1, n: 3, hi: 4'h0, lo: 4'hF}; vecs.push_back(v);
    v = '{r: 1'b1, n: 1, hi: 4'h1, lo: 4'hE}; vecs.push_back(v);
    for (int k = 2; k <= 16; k++) begin
      v.r  = 1'b1;
      v.n  = 4;
      v.hi = 4'(k % 16);
      v.lo = ~4'(k % 16);
      vecs.push_back(v);
    end
    // 23 more edges leave presc==3, cnt==5; reset on the very next (tick) edge.
    v = '{r: 1'b1, n: 23, hi: 4'h5, lo: 4'hA}; vecs.push_back(v);
    v = '{r: 1'b0, n: 1,  hi: 4'h0, lo: 4'hF}; vecs.push_back(v);
    v = '{r: 1'b1, n: 3,  hi: 4'h0, lo: 4'hF}; vecs.push_back(v);
    v = '{r: 1'b1, n: 1,  hi: 4'h1, lo: 4'hE}; vecs.push_back(v);

    foreach (vecs[i])
      apply(vecs[i].r, vecs[i].n, $sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);

    // Glitch rstn between edges: nothing may change, and counting resumes untouched.
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
    check("glitch_hold_hi", hi, 4'h1);
    check("glitch_hold_lo", lo, 4'hE);
    apply_model(1'b1, 3, "glitch_run3");
    apply_model(1'b1, 1, "glitch_tick");

    // Long run: the DIV=1000 counter must step exactly at every 1000th edge.
    apply_model(1'b0, 1, "big_reset");
    for (int k = 1; k <= 5; k++) begin
      apply_model(1'b1, 999, $sformatf("big_pre%0d", k));
      apply_model(1'b1, 1,   $sformatf("big_step%0d", k));
    end

    check("sb_drained", 4'(sb.size()), 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
